// File: rtl/epochtv1_vram_arb.sv
// Epoch TV-1 VRAM bus arbiter: one registered grant per pixel slot between the
// CPU, background fetch and sprite fetch, with write strobes and read-valid strobes.
module epochtv1_vram_arb #(
  parameter int unsigned STARVE_MAX    = 4,
  parameter int unsigned RECOVER_SLOTS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [12:0] CPU_A,
  input  logic        BG_REQ,
  input  logic [11:0] BG_A,
  input  logic        SPR_REQ,
  input  logic [11:0] SPR_A,
  output logic [11:0] VA,
  output logic        nVAWR,
  output logic        nVBWR,
  output logic        GNT_CPU,
  output logic        GNT_BG,
  output logic        GNT_SPR,
  output logic        RV_CPU,
  output logic        RV_BG,
  output logic        RV_SPR,
  output logic        SPR_STALL
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);
  localparam logic [1:0] REC_LOAD  = 2'(RECOVER_SLOTS - 1);

  state_t      state_q, state_d;
  logic [1:0]  rec_cnt_q, rec_cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [11:0] va_q, va_d;
  logic        nvawr_q, nvawr_d;
  logic        nvbwr_q, nvbwr_d;
  logic        gnt_cpu_q, gnt_cpu_d;
  logic        gnt_bg_q, gnt_bg_d;
  logic        gnt_spr_q, gnt_spr_d;
  logic        rv_cpu_q, rv_cpu_d;
  logic        rv_bg_q, rv_bg_d;
  logic        rv_spr_q, rv_spr_d;
  logic        first_slot_s;
  logic        recovering_s;
  logic        force_spr_s;

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    starve_d  = starve_q;
    va_d      = va_q;
    nvawr_d   = 1'b1;
    nvbwr_d   = 1'b1;
    gnt_cpu_d = 1'b0;
    gnt_bg_d  = 1'b0;
    gnt_spr_d = 1'b0;

    // The slot after CPU_REQ drops already counts as a recovery slot.
    first_slot_s = CPU_REQ && (state_q != ST_CPU);
    recovering_s = ((state_q == ST_CPU) && !CPU_REQ) ||
                   ((state_q == ST_RECOVER) && (rec_cnt_q != 2'd0));
    force_spr_s  = SPR_REQ && (starve_q >= STARVE_TH);

    if (CPU_REQ) begin
      gnt_cpu_d = 1'b1;
      va_d      = CPU_A[12:1];
      nvawr_d   = ~(first_slot_s & CPU_WE & ~CPU_A[0]);
      nvbwr_d   = ~(first_slot_s & CPU_WE & CPU_A[0]);
    end else if (recovering_s) begin
      va_d = va_q;
    end else if (force_spr_s) begin
      gnt_spr_d = 1'b1;
      va_d      = SPR_A;
    end else if (BG_REQ) begin
      gnt_bg_d = 1'b1;
      va_d     = BG_A;
    end else if (SPR_REQ) begin
      gnt_spr_d = 1'b1;
      va_d      = SPR_A;
    end else begin
      va_d = va_q;
    end

    if (!SPR_REQ || gnt_spr_d) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'd15) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (CPU_REQ) state_d = ST_CPU;
        else         state_d = ST_IDLE;
      end
      ST_CPU: begin
        if (!CPU_REQ) begin
          state_d   = ST_RECOVER;
          rec_cnt_d = REC_LOAD;
        end else begin
          state_d = ST_CPU;
        end
      end
      ST_RECOVER: begin
        if (CPU_REQ) begin
          state_d = ST_CPU;
        end else if (rec_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rec_cnt_d = 2'd0;
      end
    endcase

    // Data for a write slot never comes back, so no read-valid for it.
    rv_cpu_d = gnt_cpu_q & nvawr_q & nvbwr_q;
    rv_bg_d  = gnt_bg_q;
    rv_spr_d = gnt_spr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rec_cnt_q <= 2'd0;
      starve_q  <= 4'd0;
      va_q      <= 12'd0;
      nvawr_q   <= 1'b1;
      nvbwr_q   <= 1'b1;
      gnt_cpu_q <= 1'b0;
      gnt_bg_q  <= 1'b0;
      gnt_spr_q <= 1'b0;
      rv_cpu_q  <= 1'b0;
      rv_bg_q   <= 1'b0;
      rv_spr_q  <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      starve_q  <= starve_d;
      va_q      <= va_d;
      nvawr_q   <= nvawr_d;
      nvbwr_q   <= nvbwr_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_bg_q  <= gnt_bg_d;
      gnt_spr_q <= gnt_spr_d;
      rv_cpu_q  <= rv_cpu_d;
      rv_bg_q   <= rv_bg_d;
      rv_spr_q  <= rv_spr_d;
    end
  end

  assign VA        = va_q;
  assign nVAWR     = nvawr_q;
  assign nVBWR     = nvbwr_q;
  assign GNT_CPU   = gnt_cpu_q;
  assign GNT_BG    = gnt_bg_q;
  assign GNT_SPR   = gnt_spr_q;
  assign RV_CPU    = rv_cpu_q;
  assign RV_BG     = rv_bg_q;
  assign RV_SPR    = rv_spr_q;
  assign SPR_STALL = ~gnt_spr_q & SPR_REQ;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Table-driven bench for epochtv1_vram_arb: two instances (RECOVER_SLOTS 1 and 3)
// share stimulus; expected slot outputs go through a scoreboard queue.
module tb_epochtv1_vram_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b1;
  logic        CPU_REQ = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [12:0] CPU_A = 13'd0;
  logic        BG_REQ = 1'b0;
  logic [11:0] BG_A = 12'd0;
  logic        SPR_REQ = 1'b0;
  logic [11:0] SPR_A = 12'd0;

  logic [11:0] va0, va3;
  logic        nva0, nvb0, gc0, gb0, gs0, rc0, rb0, rs0, st0;
  logic        nva3, nvb3, gc3, gb3, gs3, rc3, rb3, rs3, st3;
  logic [20:0] obs0, obs3;

  epochtv1_vram_arb dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A),
    .BG_REQ(BG_REQ), .BG_A(BG_A), .SPR_REQ(SPR_REQ), .SPR_A(SPR_A),
    .VA(va0), .nVAWR(nva0), .nVBWR(nvb0), .GNT_CPU(gc0), .GNT_BG(gb0), .GNT_SPR(gs0),
    .RV_CPU(rc0), .RV_BG(rb0), .RV_SPR(rs0), .SPR_STALL(st0)
  );

  epochtv1_vram_arb #(.STARVE_MAX(4), .RECOVER_SLOTS(3)) dut3 (
    .CLK(CLK), .RST(RST), .CE(CE), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A),
    .BG_REQ(BG_REQ), .BG_A(BG_A), .SPR_REQ(SPR_REQ), .SPR_A(SPR_A),
    .VA(va3), .nVAWR(nva3), .nVBWR(nvb3), .GNT_CPU(gc3), .GNT_BG(gb3), .GNT_SPR(gs3),
    .RV_CPU(rc3), .RV_BG(rb3), .RV_SPR(rs3), .SPR_STALL(st3)
  );

  assign obs0 = {va0, nva0, nvb0, gc0, gb0, gs0, rc0, rb0, rs0, st0};
  assign obs3 = {va3, nva3, nvb3, gc3, gb3, gs3, rc3, rb3, rs3, st3};

  always #5 CLK = ~CLK;

  // ctl = {rst, ce, sel(0=dut,1=dut3)}, req = {cpu_req, cpu_we, bg_req, spr_req}
  // exp = {va, nVAWR, nVBWR, gnt{cpu,bg,spr}, rv{cpu,bg,spr}, spr_stall}
  typedef struct {
    logic [2:0]  ctl;
    logic [3:0]  req;
    logic [12:0] ca;
    logic [11:0] ba;
    logic [11:0] sa;
    logic [20:0] exp;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [20:0] exp;
    int          idx;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t R(input logic [2:0] ctl, input logic [3:0] req,
                             input logic [12:0] ca, input logic [11:0] ba, input logic [11:0] sa,
                             input logic [11:0] va, input logic [1:0] nw, input logic [2:0] g,
                             input logic [2:0] rv, input logic st);
    vec_t v;
    v.ctl = ctl; v.req = req; v.ca = ca; v.ba = ba; v.sa = sa;
    v.exp = {va, nw, g, rv, st};
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [20:0] got, input logic [20:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s[%0d]: got va=%h nw=%b gnt=%b rv=%b stall=%b, expected va=%h nw=%b gnt=%b rv=%b stall=%b",
               nm, idx, got[20:9], got[8:7], got[6:4], got[3:1], got[0],
               exp[20:9], exp[8:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic pop_and_check(input string nm);
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
    end else begin
      e = sb.pop_front();
      check(nm, e.idx, e.sel ? obs3 : obs0, e.exp);
    end
  endtask

  initial begin
    int low_cnt;
    // Reset held with every requester active.
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(3'b110, 4'b1011, 13'h0010, 12'h111, 12'h222, 12'h000, 2'b11, 3'b000, 3'b000, 1'b1));
    // First CE after release grants CPU; CPU drop gives one empty slot.
    tbl.push_back(R(3'b010, 4'b1011, 13'h0010, 12'h111, 12'h222, 12'h008, 2'b11, 3'b100, 3'b000, 1'b1));
    tbl.push_back(R(3'b010, 4'b0011, 13'h0010, 12'h111, 12'h222, 12'h008, 2'b11, 3'b000, 3'b100, 1'b1));
    tbl.push_back(R(3'b010, 4'b0000, 13'h0010, 12'h111, 12'h222, 12'h008, 2'b11, 3'b000, 3'b000, 1'b0));
    // CPU write, lane B, three slots.
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5B, 12'h111, 12'h222, 12'h52D, 2'b10, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5B, 12'h111, 12'h222, 12'h52D, 2'b11, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5B, 12'h111, 12'h222, 12'h52D, 2'b11, 3'b100, 3'b100, 1'b0));
    tbl.push_back(R(3'b010, 4'b0100, 13'h0A5B, 12'h111, 12'h222, 12'h52D, 2'b11, 3'b000, 3'b100, 1'b0));
    tbl.push_back(R(3'b010, 4'b0100, 13'h0A5B, 12'h111, 12'h222, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    // CPU read with BG pending, then BG back-to-back.
    tbl.push_back(R(3'b010, 4'b1010, 13'h1FFE, 12'h3C7, 12'h222, 12'hFFF, 2'b11, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b1010, 13'h1FFE, 12'h3C7, 12'h222, 12'hFFF, 2'b11, 3'b100, 3'b100, 1'b0));
    tbl.push_back(R(3'b010, 4'b0010, 13'h1FFE, 12'h3C7, 12'h222, 12'hFFF, 2'b11, 3'b000, 3'b100, 1'b0));
    tbl.push_back(R(3'b010, 4'b0010, 13'h1FFE, 12'h3C7, 12'h222, 12'h3C7, 2'b11, 3'b010, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0010, 13'h1FFE, 12'h3C8, 12'h222, 12'h3C8, 2'b11, 3'b010, 3'b010, 1'b0));
    tbl.push_back(R(3'b010, 4'b0000, 13'h1FFE, 12'h3C8, 12'h222, 12'h3C8, 2'b11, 3'b000, 3'b010, 1'b0));
    // Sprite starvation: BG x4 then forced SPR, twice.
    tbl.push_back(R(3'b010, 4'b0011, 13'h1FFE, 12'h100, 12'h200, 12'h100, 2'b11, 3'b010, 3'b000, 1'b1));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++)
        tbl.push_back(R(3'b010, 4'b0011, 13'h1FFE, 12'h100, 12'h200, 12'h100, 2'b11, 3'b010, 3'b010, 1'b1));
      tbl.push_back(R(3'b010, 4'b0011, 13'h1FFE, 12'h100, 12'h200, 12'h200, 2'b11, 3'b001, 3'b010, 1'b0));
      tbl.push_back(R(3'b010, 4'b0011, 13'h1FFE, 12'h100, 12'h200, 12'h100, 2'b11, 3'b010, 3'b001, 1'b1));
    end
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(3'b010, 4'b0011, 13'h1FFE, 12'h100, 12'h200, 12'h100, 2'b11, 3'b010, 3'b010, 1'b1));
    // CPU rises while sprite is due: CPU wins, sprite still forced afterwards.
    tbl.push_back(R(3'b010, 4'b1011, 13'h0002, 12'h100, 12'h200, 12'h001, 2'b11, 3'b100, 3'b010, 1'b1));
    tbl.push_back(R(3'b010, 4'b0011, 13'h0002, 12'h100, 12'h200, 12'h001, 2'b11, 3'b000, 3'b100, 1'b1));
    tbl.push_back(R(3'b010, 4'b0011, 13'h0002, 12'h100, 12'h200, 12'h200, 2'b11, 3'b001, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0000, 13'h0002, 12'h100, 12'h200, 12'h200, 2'b11, 3'b000, 3'b001, 1'b0));
    // Lane A write, drop, re-request inside recovery: second write strobe.
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5A, 12'h100, 12'h200, 12'h52D, 2'b01, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0100, 13'h0A5A, 12'h100, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5A, 12'h100, 12'h200, 12'h52D, 2'b01, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0100, 13'h0A5A, 12'h100, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0100, 13'h0A5A, 12'h100, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    // Reset during a write slot with CE low: strobe cleared, no RV afterwards.
    tbl.push_back(R(3'b010, 4'b1100, 13'h0A5B, 12'h100, 12'h200, 12'h52D, 2'b10, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b100, 4'b1100, 13'h0A5B, 12'h100, 12'h200, 12'h000, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b010, 4'b0000, 13'h0A5B, 12'h100, 12'h200, 12'h000, 2'b11, 3'b000, 3'b000, 1'b0));
    // RECOVER_SLOTS=3 instance: preempt in 2nd recovery slot, then three idle slots.
    tbl.push_back(R(3'b111, 4'b0000, 13'h0A5B, 12'h123, 12'h200, 12'h000, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b1110, 13'h0A5B, 12'h123, 12'h200, 12'h52D, 2'b10, 3'b100, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b0110, 13'h0A5B, 12'h123, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b0110, 13'h0A5B, 12'h123, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b1110, 13'h0A5B, 12'h123, 12'h200, 12'h52D, 2'b10, 3'b100, 3'b000, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(3'b011, 4'b0110, 13'h0A5B, 12'h123, 12'h200, 12'h52D, 2'b11, 3'b000, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b0010, 13'h0A5B, 12'h123, 12'h200, 12'h123, 2'b11, 3'b010, 3'b000, 1'b0));
    tbl.push_back(R(3'b011, 4'b0000, 13'h0A5B, 12'h123, 12'h200, 12'h123, 2'b11, 3'b000, 3'b010, 1'b0));

    foreach (tbl[i]) begin
      sb_t e;
      {RST, CE} = tbl[i].ctl[2:1];
      {CPU_REQ, CPU_WE, BG_REQ, SPR_REQ} = tbl[i].req;
      CPU_A = tbl[i].ca;
      BG_A  = tbl[i].ba;
      SPR_A = tbl[i].sa;
      e.sel = tbl[i].ctl[0];
      e.exp = tbl[i].exp;
      e.idx = i;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      pop_and_check("vec");
    end

    // CE every 4th CLK during a lane A write: strobe spans exactly one slot.
    RST = 1'b1; CE = 1'b1;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; BG_REQ = 1'b0; SPR_REQ = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_A = 13'h0A5A;
    low_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      sb_t e;
      CE = (k % 4 == 0);
      e.sel = 1'b0;
      e.idx = k;
      e.exp = {12'h52D, (k < 4) ? 1'b0 : 1'b1, 1'b1, 3'b100, (k >= 8) ? 3'b100 : 3'b000, 1'b0};
      sb.push_back(e);
      @(posedge CLK);
      #1;
      if (nva0 == 1'b0) low_cnt = low_cnt + 1;
      pop_and_check("ce_gate");
    end
    n_cmp = n_cmp + 1;
    if (low_cnt != 4) begin
      n_err = n_err + 1;
      $display("FAIL ce_gate_strobe_len: got %0d CLK low, expected 4", low_cnt);
    end
    CE = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/epochtv1_vram_arb.md
# epochtv1_vram_arb

Slot-based VRAM bus arbiter for the Epoch TV-1 video chip. It shares the single 12-bit VRAM address bus (A/B byte lanes) between three requesters: the CPU interface, the background fetch pipeline and the sprite fetch pipeline. One grant is issued per pixel-clock slot (CE). The block generates the registered VRAM address, the active-low write strobes and per-requester read-data-valid strobes. It sits between the epochtv1 CPU decoder / fetch engines and the external VRAM pins.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive denied sprite slots (1-15) before the sprite requester is forced ahead of background.
- RECOVER_SLOTS, 1: idle slots (1-3) inserted after a CPU access ends, before a fetch requester is granted.

Ports:
- CLK  in  1  system clock (XTAL*2)
- RST  in  1  reset; synchronous, active-high
- CE  in  1  pixel-clock enable; all state advances only on CLK edges with CE=1
- CPU_REQ  in  1  CPU VRAM cycle active (level, held for whole bus cycle)
- CPU_WE  in  1  CPU cycle is a write
- CPU_A  in  13  CPU byte address; [12:1]=VRAM word, [0]=lane (0=A, 1=B)
- BG_REQ  in  1  background fetch request (level, held until granted)
- BG_A  in  12  background word address
- SPR_REQ  in  1  sprite fetch request (level, held until granted)
- SPR_A  in  12  sprite word address
- VA  out  12  VRAM word address to both lanes (registered)
- nVAWR  out  1  lane A write strobe, active-low (registered)
- nVBWR  out  1  lane B write strobe, active-low (registered)
- GNT_CPU, GNT_BG, GNT_SPR  out  1 each  one-hot grant for the current slot (registered)
- RV_CPU, RV_BG, RV_SPR  out  1 each  VAD_I/VBD_I hold data for that requester's read in this slot
- SPR_STALL  out  1  sprite pipeline must hold state this slot (=~GNT_SPR & SPR_REQ)

## Operation
- FSM states: IDLE, CPU, RECOVER.
  - IDLE -> CPU when CPU_REQ=1 at a CE edge.
  - CPU -> RECOVER when CPU_REQ=0 at a CE edge. The recovery counter is loaded with RECOVER_SLOTS-1.
  - RECOVER -> IDLE when the counter reaches 0.
  - RECOVER -> CPU when CPU_REQ=1 at any RECOVER edge. The CPU always preempts.
- Arbitration at each CE edge; the result is registered for the next slot.
  - CPU_REQ=1: grant CPU. VA=CPU_A[12:1].
  - Else if state is RECOVER: no grant. VA holds its previous value.
  - Else if SPR_REQ and starve_cnt>=STARVE_MAX: grant SPR.
  - Else if BG_REQ: grant BG.
  - Else if SPR_REQ: grant SPR.
  - Else no grant. VA holds.
- Writes:
  - nVAWR/nVBWR go low only in the first granted slot of a CPU access, i.e. the CE edge on which the state leaves IDLE or RECOVER.
  - CPU_WE=1 in that slot selects the lane by CPU_A[0].
  - Further slots of the same access are reads-only. There is no duplicate write.
- starve_cnt (4-bit):
  - Cleared on GNT_SPR and whenever SPR_REQ=0.
  - Incremented, saturating at 15, on each CE edge where SPR_REQ=1 and SPR is not granted, including CPU and RECOVER slots.
- Read-valid:
  - RV_x = registered copy of GNT_x, updated on CE. Synchronous VRAM returns data one slot after the address.
  - RV_CPU is suppressed for the write slot.
- A requester that drops its REQ is never granted on that edge. Grant reflects the REQ sampled at that edge only.

## Timing
- Reset values (RST=1 at any CLK edge, regardless of CE):
  - VA=0, nVAWR=nVBWR=1, all GNT_* and RV_* =0.
  - State=IDLE, starve_cnt=0, recovery counter=0.
  - SPR_STALL follows its combinational definition, so it is 1 if SPR_REQ=1.
- Reset mid-access: any in-flight write strobe is deasserted on the reset edge. No RV follows.
- Latency:
  - Request sampled at CE edge n -> GNT/VA/strobes valid during slot n+1 -> RV during slot n+2.
- Back-to-back BG requests are granted every slot (throughput 1/slot).
- SPR_STALL is combinational from the registered GNT_SPR and the live SPR_REQ.
- Simultaneous events:
  - CPU_REQ rising on the same edge as a forced-sprite condition: CPU wins, starve_cnt increments.
  - CPU_REQ deasserting and reasserting within RECOVER: a new access begins, with a new write slot if CPU_WE.
- CE=0 edges: all registers hold, including strobes. A write strobe therefore spans exactly one CE slot.

## Test plan
- Reset: assert RST for 3 CLK with all REQ=1 -> VA=0, nVAWR=nVBWR=1, GNT_*=0, RV_*=0. After release, the first CE edge grants CPU.
- CPU write: CPU_REQ=1, CPU_WE=1, CPU_A=13'h0A5B for 3 slots -> VA=12'h52D. nVBWR=0 for exactly the first slot only. nVAWR stays 1. Then 1 RECOVER slot with no grant (RECOVER_SLOTS=1).
- CPU read then fetch: CPU read of 2 slots with BG_REQ=1 throughout -> GNT_CPU 2 slots, RV_CPU 2 slots (lagging by 1), one empty slot, then GNT_BG with VA=BG_A.
- Sprite starvation: BG_REQ and SPR_REQ held continuously, STARVE_MAX=4 -> pattern BG,BG,BG,BG,SPR repeating. SPR_STALL=0 only in the SPR slots. starve_cnt returns to 0 after each SPR grant.
- Preemption in recovery: RECOVER_SLOTS=3, CPU_REQ re-asserts in the 2nd recovery slot -> CPU granted next slot. A new write strobe is issued if CPU_WE=1.
- CE gating: CE toggles every 4th CLK during a CPU write -> nVAWR low for exactly 4 CLK (one slot). All outputs are stable between CE edges.
